// File: rtl/axis_eth_fcs_check.sv
// Ethernet FCS checker on an 8-bit AXI-Stream.
// Strips the 4 trailing FCS bytes and flags bad-CRC frames on the last payload beat.
// It also pulses an error for frames too short to carry any payload.
//
// Handshake: a beat moves on either side only on a clock edge where valid and
// ready are both high. A valid beat is held stable until it is taken. Ready may
// drop at any time.
module axis_eth_fcs_check (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       busy,
    output logic       error_bad_fcs,
    output logic       error_bad_frame
);

    typedef enum logic [1:0] {IDLE, FILL, PAYLOAD} state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    state_t      state_q;
    logic [2:0]  count_q;
    logic [31:0] crc_q, crc_d;
    logic [31:0] sr_q;
    logic        bad_fcs_q, bad_frame_q;

    logic        accept;
    logic        fcs_mismatch;
    logic        int_valid;
    logic [7:0]  int_data;
    logic        int_last, int_user;

    logic        s_ready_q, s_ready_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q;
    logic        m_last_q, m_user_q;
    logic        t_valid_q, t_valid_d;
    logic [7:0]  t_data_q;
    logic        t_last_q, t_user_q;
    logic        load_out_int, load_out_temp, load_temp_int;

    assign accept       = s_axis_tvalid & s_ready_q;
    assign fcs_mismatch = (crc_d != CRC_RESIDUE);

    // Internal beat: the oldest held byte, produced whenever a byte is accepted with 4 held.
    assign int_valid = accept & (state_q == PAYLOAD);
    assign int_data  = sr_q[31:24];
    assign int_last  = s_axis_tlast;
    assign int_user  = s_axis_tuser | fcs_mismatch;

    // Byte-wise reflected CRC-32 update with the incoming byte.
    always_comb begin
        crc_d = crc_q ^ {24'h0, s_axis_tdata};
        for (int i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
        end
    end

    // Frame FSM: fill level, CRC accumulation and error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= 3'd0;
            crc_q       <= CRC_INIT;
            bad_fcs_q   <= 1'b0;
            bad_frame_q <= 1'b0;
        end else begin
            bad_fcs_q   <= 1'b0;
            bad_frame_q <= 1'b0;
            if (accept) begin
                if (s_axis_tlast) begin
                    state_q <= IDLE;
                    count_q <= 3'd0;
                    crc_q   <= CRC_INIT;
                    if (state_q == PAYLOAD) begin
                        bad_fcs_q <= fcs_mismatch;
                    end else begin
                        bad_frame_q <= 1'b1;
                    end
                end else begin
                    crc_q <= crc_d;
                    unique case (state_q)
                        IDLE: begin
                            state_q <= FILL;
                            count_q <= 3'd1;
                        end
                        FILL: begin
                            count_q <= count_q + 3'd1;
                            if (count_q == 3'd3) begin
                                state_q <= PAYLOAD;
                            end
                        end
                        PAYLOAD: count_q <= 3'd4;
                        default: begin
                            state_q <= IDLE;
                            count_q <= 3'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Four-byte delay line. Its contents become meaningless once the fill count is cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            sr_q <= {sr_q[23:0], s_axis_tdata};
        end
    end

    // Skid buffer steering: route the internal beat to the output register or to temp.
    always_comb begin
        m_valid_d     = m_valid_q;
        t_valid_d     = t_valid_q;
        load_out_int  = 1'b0;
        load_out_temp = 1'b0;
        load_temp_int = 1'b0;
        if (s_ready_q) begin
            if (m_axis_tready || !m_valid_q) begin
                m_valid_d    = int_valid;
                load_out_int = 1'b1;
            end else begin
                t_valid_d     = int_valid;
                load_temp_int = 1'b1;
            end
        end else if (m_axis_tready) begin
            m_valid_d     = t_valid_q;
            t_valid_d     = 1'b0;
            load_out_temp = 1'b1;
        end
        s_ready_d = m_axis_tready | (~t_valid_q & (~m_valid_q | ~int_valid));
    end

    // Skid buffer valid flags and registered input ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            t_valid_q <= 1'b0;
        end else begin
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            t_valid_q <= t_valid_d;
        end
    end

    // Skid buffer payload registers. These are don't-care while their valid flag is low.
    always_ff @(posedge clk) begin
        if (load_out_int) begin
            m_data_q <= int_data;
            m_last_q <= int_last;
            m_user_q <= int_user;
        end else if (load_out_temp) begin
            m_data_q <= t_data_q;
            m_last_q <= t_last_q;
            m_user_q <= t_user_q;
        end
        if (load_temp_int) begin
            t_data_q <= int_data;
            t_last_q <= int_last;
            t_user_q <= int_user;
        end
    end

    assign s_axis_tready   = s_ready_q;
    assign m_axis_tvalid   = m_valid_q;
    assign m_axis_tdata    = m_data_q;
    assign m_axis_tlast    = m_last_q;
    assign m_axis_tuser    = m_user_q;
    assign busy            = (state_q != IDLE);
    assign error_bad_fcs   = bad_fcs_q;
    assign error_bad_frame = bad_frame_q;

endmodule

// File: tb/tb_axis_eth_fcs_check.sv
// Bench for axis_eth_fcs_check.
// Frames are built from random bytes. The expected output is derived per frame:
// the last four bytes are dropped, and a table-driven CRC-32 of the payload is
// compared with the little-endian FCS.
module tb_axis_eth_fcs_check;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] s_axis_tdata  = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast  = 1'b0;
  logic       s_axis_tuser  = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast;
  logic       m_axis_tuser;
  logic       busy;
  logic       error_bad_fcs;
  logic       error_bad_frame;

  axis_eth_fcs_check dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .busy            (busy),
    .error_bad_fcs   (error_bad_fcs),
    .error_bad_frame (error_bad_frame)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];        // {user, last, data}
  logic [7:0] frame_buf[$];
  logic [31:0] crc_tab[256];
  int exp_fcs = 0, exp_frame = 0;
  int seen_fcs = 0, seen_frame = 0;
  int rdy_pct = 100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) c = crc_tab[c[7:0] ^ frame_buf[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic model_frame(input logic tuser_in, input logic do_last);
    int n = frame_buf.size();
    logic [31:0] fcs;
    logic bad;
    if (!do_last) begin
      for (int i = 0; i < n - 4; i++) exp_q.push_back({2'b00, frame_buf[i]});
      return;
    end
    if (n <= 4) begin
      exp_frame++;
      return;
    end
    fcs = {frame_buf[n-1], frame_buf[n-2], frame_buf[n-3], frame_buf[n-4]};
    bad = (crc32(n - 4) != fcs);
    for (int i = 0; i < n - 4; i++) begin
      if (i == n - 5) exp_q.push_back({tuser_in | bad, 1'b1, frame_buf[i]});
      else            exp_q.push_back({2'b00, frame_buf[i]});
    end
    if (bad) exp_fcs++;
  endtask

  task automatic build_frame(input int payload_len, input logic corrupt);
    logic [31:0] fcs;
    int k;
    frame_buf.delete();
    for (int i = 0; i < payload_len; i++) frame_buf.push_back(8'($urandom_range(255)));
    fcs = crc32(payload_len);
    for (int i = 0; i < 4; i++) frame_buf.push_back(fcs[8*i +: 8]);
    if (corrupt) begin
      k = $urandom_range(frame_buf.size() - 1);
      frame_buf[k] = frame_buf[k] ^ (8'h01 << $urandom_range(7));
    end
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    m_axis_tready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
  end

  // Called at posedge+1; returns at posedge+1 right after the final byte is accepted.
  task automatic send_frame(input logic tuser_in, input logic do_last, input int gap_pct);
    int n = frame_buf.size();
    int wd;
    model_frame(tuser_in, do_last);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_axis_tdata  = frame_buf[i];
      s_axis_tlast  = do_last && (i == n - 1);
      s_axis_tuser  = s_axis_tlast ? tuser_in : 1'($urandom_range(1));
      s_axis_tvalid = 1'b1;
      wd = 0;
      do begin
        @(negedge clk);
        wd++;
      end while (!s_axis_tready && wd < 500);
      if (!s_axis_tready) check("s_ready_timeout", s_axis_tready, 1'b1);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_pending_beats"}, exp_q.size(), 0);
    check({tag, "_bad_fcs_pulses"}, seen_fcs, exp_fcs);
    check({tag, "_bad_frame_pulses"}, seen_frame, exp_frame);
    check({tag, "_busy_idle"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (error_bad_fcs === 1'b1) seen_fcs++;
    if (error_bad_frame === 1'b1) seen_frame++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", m_axis_tvalid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", m_axis_tdata, e[7:0]);
        check("beat_last", m_axis_tlast, e[8]);
        if (e[8]) check("beat_user", m_axis_tuser, e[9]);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] good_frame[13];
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[n] = c;
    end
    good_frame = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                   8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_axis_tready, 1'b0);
    check("rst_m_valid", m_axis_tvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_bad_fcs", error_bad_fcs, 1'b0);
    check("rst_bad_frame", error_bad_frame, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_pct = 100;
    @(posedge clk);
    #1;

    // Good "123456789" frame
    frame_buf.delete();
    foreach (good_frame[i]) frame_buf.push_back(good_frame[i]);
    send_frame(1'b0, 1'b1, 0);
    drain_and_check("good");

    // Corrupted last FCS byte
    frame_buf[12] = 8'hCA;
    send_frame(1'b0, 1'b1, 0);
    drain_and_check("corrupt");

    // Short frame of 3 bytes
    frame_buf.delete();
    for (int i = 0; i < 3; i++) frame_buf.push_back(8'($urandom_range(255)));
    send_frame(1'b0, 1'b1, 0);
    drain_and_check("short");

    // Upstream error on an otherwise good frame
    frame_buf.delete();
    foreach (good_frame[i]) frame_buf.push_back(good_frame[i]);
    send_frame(1'b1, 1'b1, 0);
    drain_and_check("upstream_err");

    // Two back-to-back 64-byte frames under 50% downstream backpressure
    rdy_pct = 50;
    build_frame(60, 1'b0);
    send_frame(1'b0, 1'b1, 0);
    build_frame(60, 1'b0);
    send_frame(1'b0, 1'b1, 0);
    drain_and_check("backpressure");

    // Reset mid-frame after the 10th byte, then a good frame
    rdy_pct = 100;
    build_frame(20, 1'b0);
    frame_buf = frame_buf[0:9];
    send_frame(1'b0, 1'b0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_m_valid", m_axis_tvalid, 1'b0);
    check("midrst_s_ready", s_axis_tready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    build_frame(30, 1'b0);
    send_frame(1'b0, 1'b1, 0);
    drain_and_check("after_reset");

    // Random frames with gaps, backpressure, corruption and short lengths
    rdy_pct = 60;
    for (int f = 0; f < 8; f++) begin
      build_frame($urandom_range(0, 20), ($urandom_range(99) < 30));
      if ($urandom_range(3) == 0) frame_buf = frame_buf[0:$urandom_range(3)];
      send_frame(1'($urandom_range(1)), 1'b1, 30);
    end
    drain_and_check("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_eth_fcs_check.md
AXIS_ETH_FCS_CHECK -- requirements
Module: axis_eth_fcs_check

Interface
REQ-001: The block SHALL have no parameters; the data width is fixed at 8 bits.
REQ-002: clk  input  1  clock; all logic is on the rising edge.
REQ-003: rst  input  1  reset, synchronous, active-low; asserted while 0.
REQ-004: s_axis_tdata  input  8  received frame byte; the frame includes the 4 FCS bytes.
REQ-005: s_axis_tvalid  input  1  input byte valid.
REQ-006: s_axis_tready  output  1  input ready; registered.
REQ-007: s_axis_tlast  input  1  last byte of the frame, which is the final FCS byte.
REQ-008: s_axis_tuser  input  1  upstream error flag; sampled only on the tlast beat.
REQ-009: m_axis_tdata  output  8  payload byte with the FCS stripped.
REQ-010: m_axis_tvalid  output  1  output valid.
REQ-011: m_axis_tready  input  1  downstream ready.
REQ-012: m_axis_tlast  output  1  last payload byte.
REQ-013: m_axis_tuser  output  1  frame error; meaningful only with m_axis_tlast.
REQ-014: busy  output  1  high while a frame is in progress (state not IDLE).
REQ-015: error_bad_fcs  output  1  one-cycle pulse when a frame ends with an FCS mismatch.
REQ-016: error_bad_frame  output  1  one-cycle pulse when a frame of 4 bytes or fewer is discarded.

Function
REQ-017: The CRC SHALL be Ethernet CRC-32: polynomial 0x04C11DB7, reflected, Galois form, 8 bits per update, init 0xFFFFFFFF.
REQ-018: The CRC SHALL be updated with every accepted input byte, including the FCS bytes.
REQ-019: The frame is good when the CRC state after the tlast byte equals 0xDEBB20E3.
REQ-020: A 4-byte shift register SHALL delay the data, so each output byte is the input byte accepted 4 beats earlier.
REQ-021: The final 4 input bytes of each frame SHALL never be emitted.
REQ-022: State machine states:
- IDLE: 0 bytes held.
- FILL: 1-3 bytes held.
- PAYLOAD: 4 bytes held; each accepted byte emits the oldest held byte.
REQ-023: Transitions:
- IDLE -> FILL on an accepted non-last byte.
- FILL -> PAYLOAD on accepting the 4th byte.
- PAYLOAD -> IDLE on an accepted tlast.
- IDLE or FILL -> IDLE on an accepted tlast.
REQ-024: On an accepted tlast in PAYLOAD, the emitted byte SHALL carry m_axis_tlast=1 and m_axis_tuser = s_axis_tuser OR FCS mismatch.
REQ-025: On an accepted tlast in PAYLOAD, the CRC SHALL reset to 0xFFFFFFFF and the byte count SHALL reset to 0.
REQ-026: On a tlast accepted in IDLE or FILL (frame of 1-4 bytes), no output beat SHALL be produced, error_bad_frame SHALL pulse, and the CRC and count SHALL reset.
REQ-027: error_bad_fcs SHALL pulse in the cycle after an accepted tlast in PAYLOAD when the CRC mismatches, regardless of s_axis_tuser.
REQ-028: The output stage SHALL be a two-register skid buffer (output plus temp register).
REQ-029: The output stage SHALL never drop or duplicate a beat under arbitrary m_axis_tready patterns.
REQ-030: s_axis_tready SHALL be registered from the early-ready term: m_axis_tready OR (temp empty AND (output empty OR no internal valid)).
REQ-031: Latency SHALL be 1 cycle from acceptance of input byte N+4 to m_axis_tvalid for byte N.
REQ-032: Back-to-back frames SHALL be accepted with no idle cycle between the tlast beat and the next frame's first byte.
REQ-033: When tvalid=0 mid-frame, the block SHALL hold its state, shift register and CRC.
REQ-034: The byte counter SHALL saturate at 4; frame length is otherwise unbounded, with no wrap effects.

Reset
REQ-035: While rst=0 at a clock edge, the block SHALL be in state IDLE.
REQ-036: While rst=0 at a clock edge, the CRC SHALL be 0xFFFFFFFF.
REQ-037: While rst=0 at a clock edge, these outputs SHALL be 0: s_axis_tready, m_axis_tvalid, busy, error_bad_fcs, error_bad_frame; the temp register SHALL be empty.
REQ-038: Reset asserted mid-frame SHALL discard all held bytes and the partial frame, and SHALL emit no tlast.
REQ-039: After reset is released, the block SHALL resume cleanly on the next frame's first byte.
REQ-040: m_axis_tdata, m_axis_tlast and m_axis_tuser are not reset and are don't-care while m_axis_tvalid=0.

Verification
REQ-041: Good frame: input ASCII "123456789" + 26 39 F4 CB, tlast on CB, m_axis_tready=1 -> 31..39 out, tlast on 0x39, tuser=0, no error pulses.
REQ-042: Corrupted frame: same as REQ-041 with the last byte CA -> 9 bytes out, tuser=1 on the tlast beat, error_bad_fcs pulses once.
REQ-043: Short frame: 3 bytes with tlast -> no output beat, error_bad_frame pulses once, busy returns to 0.
REQ-044: Upstream error: good frame from REQ-041 with s_axis_tuser=1 on tlast -> tuser=1 out, error_bad_fcs stays 0.
REQ-045: Backpressure: two back-to-back 64-byte good frames with random m_axis_tready (50%) -> exactly 2x60 bytes out, in order, each frame with tuser=0.
REQ-046: Reset mid-frame: rst=0 for 1 cycle after the 10th byte, then a good frame -> only the second frame appears, complete and error-free.
